foc_dec_5to4: RTL and testbench

- Streaming decoder for the 4-to-5 forbidden-overlap crosstalk-avoidance code. Recovers the 4-bit symbol from each received 5-bit bus codeword.
- Sits at the receive end of an FOC-coded bus, after the bus capture flops.
- Adds a valid/ready pipeline stage, flags illegal codewords per beat, and keeps a saturating error counter for link-quality monitoring.

---
 rtl/foc_pkg.sv | 43 ++++
 rtl/foc_dec_lut.sv | 19 +
 rtl/foc_dec_5to4.sv | 95 +++++++++
 tb/tb_foc_dec_5to4.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/foc_pkg.sv
// Shared definitions for the 4-to-5 forbidden-overlap crosstalk-avoidance code.
// The codeword table below is the one both the encoder and the decoder use.
package foc_pkg;

    localparam int FOC_SYM_W = 4;
    localparam int FOC_CW_W  = 5;
    localparam int FOC_NSYM  = 16;

    // Legal codewords indexed by the 4-bit symbol they carry.
    localparam logic [FOC_CW_W-1:0] FOC_CW [FOC_NSYM] = '{
        5'b00000, 5'b00100, 5'b00001, 5'b00101,
        5'b00011, 5'b00111, 5'b10011, 5'b10111,
        5'b10000, 5'b10100, 5'b10001, 5'b10101,
        5'b11000, 5'b11100, 5'b11001, 5'b11101
    };

    // Decoded beat: illegal codewords carry err=1 and a zero symbol.
    typedef struct packed {
        logic                 err;
        logic [FOC_SYM_W-1:0] sym;
    } foc_dec_t;

    // Reverse lookup of the codeword table. Codewords that match no entry
    // are reported as illegal with symbol 0000.
    function automatic foc_dec_t foc_decode(input logic [FOC_CW_W-1:0] cw);
        foc_dec_t r;
        r.err = 1'b1;
        r.sym = '0;
        for (int i = 0; i < FOC_NSYM; i++) begin
            if (cw == FOC_CW[i]) begin
                r.err = 1'b0;
                r.sym = i[FOC_SYM_W-1:0];
            end
        end
        return r;
    endfunction

    // Forward lookup, kept beside the decoder so the table has one home.
    function automatic logic [FOC_CW_W-1:0] foc_encode(input logic [FOC_SYM_W-1:0] sym);
        return FOC_CW[sym];
    endfunction

endpackage

// File: rtl/foc_dec_lut.sv
// Combinational FOC codeword -> {err, symbol} lookup built from the shared table.
module foc_dec_lut
    import foc_pkg::*;
(
    input  logic [FOC_CW_W-1:0]  cw,
    output logic [FOC_SYM_W-1:0] sym,
    output logic                 err
);

    foc_dec_t dec;

    // Match the codeword against every legal entry; no match means illegal.
    always_comb begin
        dec = foc_decode(cw);
        sym = dec.sym;
        err = dec.err;
    end

endmodule

// File: rtl/foc_dec_5to4.sv
// Streaming FOC 5-to-4 decoder: one registered valid/ready stage, per-beat
// illegal-codeword flag, saturating error counter and sticky error bit.
module foc_dec_5to4
    import foc_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [FOC_CW_W-1:0]  data_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FOC_SYM_W-1:0] data_out,
    output logic                 out_err,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 err_sticky
);

    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

    // Handshake: a beat moves on a side when that side's valid and ready are
    // both high at a rising edge. A source holds valid/data until it moves;
    // in_ready = !out_valid || out_ready, so the stage refills in the same
    // cycle it drains and sustains one beat per cycle.
    logic                 xfer_in;
    logic                 xfer_out;
    logic [FOC_CW_W-1:0]  cw_gated;
    logic [FOC_SYM_W-1:0] lut_sym;
    logic                 lut_err;
    logic                 illegal_in;
    logic [ERR_CNT_W-1:0] cnt_base;
    logic [ERR_CNT_W-1:0] cnt_next;
    logic                 sticky_next;

    // Ready is combinational from out_ready so the stage never bubbles.
    always_comb begin
        in_ready = !out_valid || out_ready;
        xfer_in  = in_valid && in_ready;
        xfer_out = out_valid && out_ready;
    end

    // Forcing the codeword to zero when idle keeps X on an idle bus out of
    // the lookup and everything downstream of it.
    always_comb begin
        cw_gated = in_valid ? data_in : '0;
    end

    foc_dec_lut u_lut (
        .cw  (cw_gated),
        .sym (lut_sym),
        .err (lut_err)
    );

    // Error bookkeeping: clear applies first, then the current illegal beat
    // counts, so clear plus illegal leaves the counter at one.
    always_comb begin
        illegal_in  = xfer_in && lut_err;
        cnt_base    = err_clr ? '0 : err_cnt;
        sticky_next = (err_clr ? 1'b0 : err_sticky) | illegal_in;
        cnt_next    = cnt_base;
        if (illegal_in && (cnt_base != CNT_MAX)) begin
            cnt_next = cnt_base + 1'b1;
        end
    end

    // Output stage: load on transfer-in, empty on a drain with nothing new.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            out_err   <= 1'b0;
        end else if (xfer_in) begin
            out_valid <= 1'b1;
            data_out  <= lut_sym;
            out_err   <= lut_err;
        end else if (xfer_out) begin
            out_valid <= 1'b0;
        end
    end

    // Link-quality counters, independent of the data path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt    <= '0;
            err_sticky <= 1'b0;
        end else begin
            err_cnt    <= cnt_next;
            err_sticky <= sticky_next;
        end
    end

endmodule

// File: tb/tb_foc_dec_5to4.sv
// Directed bench for foc_dec_5to4: a default-width instance for the data path
// and a 2-bit-counter instance for saturation and clear.
module tb_foc_dec_5to4;

    logic       clk;
    logic       rst_n;

    logic       in_valid;
    logic       in_ready;
    logic [4:0] data_in;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] data_out;
    logic       out_err;
    logic       err_clr;
    logic [7:0] err_cnt;
    logic       err_sticky;

    logic       s_in_valid;
    logic       s_in_ready;
    logic [4:0] s_data_in;
    logic       s_out_valid;
    logic       s_out_ready;
    logic [3:0] s_data_out;
    logic       s_out_err;
    logic       s_err_clr;
    logic [1:0] s_err_cnt;
    logic       s_err_sticky;

    int         total;
    int         bad;
    int         cyc;
    int         n_out;
    logic [4:0] exp_q[$];

    foc_dec_5to4 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_in    (data_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .out_err    (out_err),
        .err_clr    (err_clr),
        .err_cnt    (err_cnt),
        .err_sticky (err_sticky)
    );

    foc_dec_5to4 #(.ERR_CNT_W(2)) dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (s_in_valid),
        .in_ready   (s_in_ready),
        .data_in    (s_data_in),
        .out_valid  (s_out_valid),
        .out_ready  (s_out_ready),
        .data_out   (s_data_out),
        .out_err    (s_out_err),
        .err_clr    (s_err_clr),
        .err_cnt    (s_err_cnt),
        .err_sticky (s_err_sticky)
    );

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bench-side copy of the encoder table, written out by hand.
    function automatic logic [4:0] enc(input logic [3:0] s);
        case (s)
            4'h0: return 5'b00000;  4'h1: return 5'b00100;
            4'h2: return 5'b00001;  4'h3: return 5'b00101;
            4'h4: return 5'b00011;  4'h5: return 5'b00111;
            4'h6: return 5'b10011;  4'h7: return 5'b10111;
            4'h8: return 5'b10000;  4'h9: return 5'b10100;
            4'hA: return 5'b10001;  4'hB: return 5'b10101;
            4'hC: return 5'b11000;  4'hD: return 5'b11100;
            4'hE: return 5'b11001;  default: return 5'b11101;
        endcase
    endfunction

    // Scoreboard: every output transfer pops the oldest expected beat.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_beat", {out_err, data_out}, 5'h1f);
            end else begin
                check("sb_beat", {out_err, data_out}, exp_q.pop_front());
            end
            n_out++;
        end
    end

    // Driver: present a codeword until accepted, queue its expected {err,sym}.
    task automatic send(input logic [4:0] cw, input logic [4:0] exp);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        data_in  = cw;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(exp);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("send_timeout", 0, 1);
        in_valid = 1'b0;
        data_in  = 5'bxxxxx;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sat_beat(input logic [4:0] cw, input logic v, input logic clr);
        s_in_valid = v;
        s_data_in  = cw;
        s_err_clr  = clr;
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        s_err_clr  = 1'b0;
    endtask

    logic [4:0] legal_cw [16];
    logic [4:0] bad_cw   [3];
    int         c0;

    initial begin
        total = 0; bad = 0; cyc = 0; n_out = 0;
        legal_cw = '{5'b00000, 5'b00100, 5'b00001, 5'b00101,
                     5'b00011, 5'b00111, 5'b10011, 5'b10111,
                     5'b10000, 5'b10100, 5'b10001, 5'b10101,
                     5'b11000, 5'b11100, 5'b11001, 5'b11101};
        bad_cw   = '{5'b01000, 5'b11111, 5'b00010};

        rst_n = 1'b0;
        in_valid = 1'b0; data_in = 5'b0; out_ready = 1'b1; err_clr = 1'b0;
        s_in_valid = 1'b0; s_data_in = 5'b0; s_out_ready = 1'b1; s_err_clr = 1'b0;

        // Reset values while held in reset.
        idle(3);
        check("rst_out_valid", out_valid, 0);
        check("rst_data_out", data_out, 0);
        check("rst_out_err", out_err, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_err_sticky", err_sticky, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Legal sweep back-to-back: latency 1, one beat per cycle.
        c0 = cyc;
        for (int s = 0; s < 16; s++) begin
            send(legal_cw[s], {1'b0, 4'(s)});
            check("sweep_valid", out_valid, 1);
            check("sweep_data", data_out, s);
            check("sweep_err", out_err, 0);
        end
        check("sweep_cycles", cyc - c0, 16);
        check("sweep_err_cnt", err_cnt, 0);

        // Round trip through the bench encoder.
        for (int s = 0; s < 16; s++) begin
            send(enc(4'(s)), {1'b0, 4'(s)});
            check("rt_data", data_out, s);
        end
        idle(1);
        check("rt_drained", out_valid, 0);

        // Idle with X on the bus must not disturb anything.
        data_in = 5'bxxxxx;
        idle(2);
        check("x_idle_valid", out_valid, 0);
        check("x_idle_err_cnt", err_cnt, 0);
        check("x_idle_sticky", err_sticky, 0);

        // Illegal codewords are delivered as 0000 with out_err set.
        for (int k = 0; k < 3; k++) begin
            send(bad_cw[k], 5'b10000);
            check("ill_data", data_out, 0);
            check("ill_err", out_err, 1);
        end
        check("ill_err_cnt", err_cnt, 3);
        check("ill_sticky", err_sticky, 1);
        send(5'b10101, 5'b01011);
        check("ill_after_data", data_out, 4'b1011);
        check("ill_after_err", out_err, 0);
        check("ill_after_cnt", err_cnt, 3);

        // Backpressure: hold 0101 for 4 cycles while 11001 waits.
        send(5'b00111, 5'b00101);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        data_in   = 5'b11001;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_valid", out_valid, 1);
            check("bp_hold_data", data_out, 4'b0101);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(5'b11001, 5'b01110);
        check("bp_next_data", data_out, 4'b1110);
        idle(2);
        check("bp_drained", out_valid, 0);
        check("bp_queue_empty", exp_q.size(), 0);

        // Saturation and clear on the 2-bit counter instance.
        for (int k = 1; k <= 5; k++) begin
            sat_beat(5'b11111, 1'b1, 1'b0);
            check("sat_cnt", s_err_cnt, (k > 3) ? 3 : k);
        end
        check("sat_sticky", s_err_sticky, 1);
        sat_beat(5'b00000, 1'b0, 1'b1);
        check("clr_cnt", s_err_cnt, 0);
        check("clr_sticky", s_err_sticky, 0);
        sat_beat(5'b01010, 1'b1, 1'b1);
        check("clr_ill_cnt", s_err_cnt, 1);
        check("clr_ill_sticky", s_err_sticky, 1);
        check("clr_ill_data_err", {s_out_valid, s_out_err, s_data_out}, 6'b110000);
        sat_beat(5'b00000, 1'b0, 1'b1);
        check("clr_keeps_path", s_out_valid, 0);

        // Async reset mid-stall: pending beat dropped with no clock edge.
        out_ready = 1'b0;
        send(5'b00101, 5'b00011);
        idle(1);
        check("ar_stalled", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_out_valid", out_valid, 0);
        check("ar_err_cnt", err_cnt, 0);
        check("ar_err_sticky", err_sticky, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ar_in_ready", in_ready, 1);
        out_ready = 1'b1;
        idle(2);

        check("final_beats", n_out, 38);
        check("final_queue", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
